// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle RV64I control path: FSM states,
// base opcodes and the encodings of the datapath select fields.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_IR   = 3'b010;
  localparam logic [2:0] ALU_IRW  = 3'b011;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

endpackage

// File: rtl/control_fsm.sv
// Multicycle RV64I control FSM: sequences fetch, decode, execute, memory
// and writeback steps and drives the datapath select/enable signals.
module control_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       arstn,
  input  logic [6:0] i_op,
  input  logic       i_alu_illegal,
  input  logic       i_mem_done,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_addr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_branch,
  output logic       o_illegal_instr,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src
);

  state_t state, state_next;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_addr_src      = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_reg_write     = 1'b0;
    o_branch        = 1'b0;
    o_illegal_instr = 1'b0;
    o_alu_op        = ALU_ADD;
    o_alu_src_a     = SRCA_PC;
    o_alu_src_b     = SRCB_RS2;
    o_result_src    = RES_ALUOUT;

    unique case (state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_done) begin
          o_ir_write   = 1'b1;
          o_pc_write   = 1'b1;
          o_alu_src_b  = SRCB_FOUR;
          o_result_src = RES_ALU;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
        unique case (i_op)
          OP_LOAD, OP_STORE: state_next = S_MEMADDR;
          OP_OP, OP_OP32:    state_next = S_EXECR;
          OP_IMM, OP_IMM32:  state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_ALUWB;
          OP_FENCE:          state_next = S_FETCH;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADDR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        state_next  = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        o_mem_req  = 1'b1;
        o_addr_src = 1'b1;
        if (i_mem_done) state_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_addr_src  = 1'b1;
        o_mem_write = 1'b1;
        if (i_mem_done) state_next = S_FETCH;
      end
      S_MEMWB: begin
        o_result_src = RES_MEM;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        o_alu_op    = i_op[3] ? ALU_IRW : ALU_IR;
        state_next  = i_alu_illegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_RS2;
        o_alu_op    = ALU_SUB;
        o_branch    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JALR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        state_next  = S_JAL;
      end
      S_JAL: begin
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALUOUT;
        o_pc_write   = 1'b1;
        state_next   = S_ALUWB;
      end
      S_LUI: begin
        o_result_src = RES_IMM;
        o_reg_write  = 1'b1;
        state_next   = S_FETCH;
      end
      S_TRAP: begin
        o_illegal_instr = 1'b1;
        state_next      = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Reset blanks every output without waiting for the state register,
    // so an in-flight memory request is withdrawn immediately.
    if (!arstn) begin
      o_mem_req       = 1'b0;
      o_mem_write     = 1'b0;
      o_addr_src      = 1'b0;
      o_ir_write      = 1'b0;
      o_pc_write      = 1'b0;
      o_reg_write     = 1'b0;
      o_branch        = 1'b0;
      o_illegal_instr = 1'b0;
      o_alu_op        = '0;
      o_alu_src_a     = '0;
      o_alu_src_b     = '0;
      o_result_src    = '0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: each instruction is expanded into its
// expected per-cycle output trace, which a compare process checks cycle by cycle.
module tb_control_fsm;

  logic       clk;
  logic       arstn;
  logic [6:0] i_op;
  logic       i_alu_illegal;
  logic       i_mem_done;
  logic       o_mem_req, o_mem_write, o_addr_src, o_ir_write;
  logic       o_pc_write, o_reg_write, o_branch, o_illegal_instr;
  logic [2:0] o_alu_op;
  logic [1:0] o_alu_src_a, o_alu_src_b, o_result_src;

  control_fsm dut (
    .clk            (clk),
    .arstn          (arstn),
    .i_op           (i_op),
    .i_alu_illegal  (i_alu_illegal),
    .i_mem_done     (i_mem_done),
    .o_mem_req      (o_mem_req),
    .o_mem_write    (o_mem_write),
    .o_addr_src     (o_addr_src),
    .o_ir_write     (o_ir_write),
    .o_pc_write     (o_pc_write),
    .o_reg_write    (o_reg_write),
    .o_branch       (o_branch),
    .o_illegal_instr(o_illegal_instr),
    .o_alu_op       (o_alu_op),
    .o_alu_src_a    (o_alu_src_a),
    .o_alu_src_b    (o_alu_src_b),
    .o_result_src   (o_result_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_write, addr_src, ir_write, pc_write, reg_write, branch,
  //  illegal, alu_op[2:0], src_a[1:0], src_b[1:0], result_src[1:0]}
  logic [16:0] dut_vec;
  assign dut_vec = {o_mem_req, o_mem_write, o_addr_src, o_ir_write, o_pc_write,
                    o_reg_write, o_branch, o_illegal_instr, o_alu_op,
                    o_alu_src_a, o_alu_src_b, o_result_src};

  typedef struct {
    logic [16:0] exp;
    logic        done;
    logic        ill;
    string       name;
  } step_t;

  step_t       q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic [16:0] exp_vec = '0;
  string       exp_name = "";

  function automatic logic [16:0] mk(input bit mr, input bit mw, input bit as,
      input bit irw, input bit pcw, input bit rw, input bit br, input bit il,
      input logic [2:0] alu, input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] r);
    return {mr, mw, as, irw, pcw, rw, br, il, alu, a, b, r};
  endfunction

  task automatic add(input logic [16:0] e, input logic d, input logic il, input string n);
    step_t s;
    s.exp = e; s.done = d; s.ill = il; s.name = n;
    q.push_back(s);
  endtask

  // Expected trace of one instruction: fetch wait cycles, decode, then the
  // opcode-specific micro-steps. noise drives done/illegal where they must be ignored.
  task automatic build(input logic [6:0] op, input int fw, input int mw,
                       input logic ill, input logic noise);
    logic [16:0] aluwb, trap, exec;
    logic        st;
    aluwb = mk(0,0,0,0,0,1,0,0, 3'd0, 2'd0, 2'd0, 2'd0);
    trap  = mk(0,0,0,0,0,0,0,1, 3'd0, 2'd0, 2'd0, 2'd0);
    q.delete();
    for (int i = 0; i < fw; i++) add(mk(1,0,0,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0), 1'b0, noise, "fetch_wait");
    add(mk(1,0,0,1,1,0,0,0, 3'd0, 2'd0, 2'd2, 2'd2), 1'b1, noise, "fetch_done");
    add(mk(0,0,0,0,0,0,0,0, 3'd0, 2'd1, 2'd1, 2'd0), noise, noise, "decode");
    case (op)
      7'b0000011, 7'b0100011: begin
        st = (op == 7'b0100011);
        add(mk(0,0,0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd0), noise, noise, "memaddr");
        for (int i = 0; i < mw; i++) add(mk(1,st,1,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0), 1'b0, noise, "mem_wait");
        add(mk(1,st,1,0,0,0,0,0, 3'd0, 2'd0, 2'd0, 2'd0), 1'b1, noise, "mem_done");
        if (!st) add(mk(0,0,0,0,0,1,0,0, 3'd0, 2'd0, 2'd0, 2'd1), noise, noise, "memwb");
      end
      7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011: begin
        exec = mk(0,0,0,0,0,0,0,0, op[3] ? 3'd3 : 3'd2, 2'd2,
                  (op[5] ? 2'd0 : 2'd1), 2'd0);
        add(exec, noise, ill, "exec");
        if (ill) add(trap, noise, 1'b0, "trap");
        else     add(aluwb, noise, noise, "aluwb");
      end
      7'b1100011: add(mk(0,0,0,0,0,0,1,0, 3'd1, 2'd2, 2'd0, 2'd0), noise, noise, "branch");
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) add(mk(0,0,0,0,0,0,0,0, 3'd0, 2'd2, 2'd1, 2'd0), noise, noise, "jalr");
        add(mk(0,0,0,0,1,0,0,0, 3'd0, 2'd1, 2'd2, 2'd0), noise, noise, "jal");
        add(aluwb, noise, noise, "aluwb");
      end
      7'b0110111: add(mk(0,0,0,0,0,1,0,0, 3'd0, 2'd0, 2'd0, 2'd3), noise, noise, "lui");
      7'b0010111: add(aluwb, noise, noise, "auipc_wb");
      7'b0001111: ;
      default:    add(trap, noise, noise, "trap");
    endcase
  endtask

  task automatic play(input logic [6:0] op, input int lim);
    int n;
    n = (lim == 0) ? q.size() : lim;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_op          = op;
      i_mem_done    = q[i].done;
      i_alu_illegal = q[i].ill;
      exp_vec       = q[i].exp;
      exp_name      = q[i].name;
      chk_en        = 1'b1;
    end
  endtask

  task automatic run(input logic [6:0] op, input int fw, input int mw,
                     input logic ill, input logic noise);
    build(op, fw, mw, ill, noise);
    play(op, 0);
  endtask

  task automatic lit(input string n, input logic [16:0] got, input logic [16:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, got, want);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (op %b)", exp_name, dut_vec, exp_vec, i_op);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arstn = 1'b0; i_op = 7'b0110011; i_mem_done = 1'b1; i_alu_illegal = 1'b1;
    #3;
    lit("reset_outputs", dut_vec, 17'h00000);
    @(negedge clk);
    arstn = 1'b1; i_mem_done = 1'b0; i_alu_illegal = 1'b0;
    #1;
    lit("fetch_after_reset", dut_vec, 17'h10000);

    // Pin the model against hand-derived ADD trace values.
    build(7'b0110011, 3, 0, 1'b0, 1'b0);
    lit("add_trace_len", 17'(q.size()), 17'd7);
    lit("add_fetch_done_vec", q[3].exp, 17'h1300A);
    lit("add_exec_vec", q[5].exp, 17'h000A0);
    play(7'b0110011, 0);

    run(7'b0000011, 2, 2, 1'b0, 1'b0);  // load
    run(7'b0111011, 1, 0, 1'b1, 1'b0);  // illegal SUBW
    run(7'b1100111, 0, 0, 1'b0, 1'b0);  // jalr
    run(7'b1110011, 0, 0, 1'b0, 1'b0);  // undefined
    run(7'b0100011, 1, 3, 1'b0, 1'b1);  // store, stray done/illegal elsewhere
    run(7'b0010011, 0, 0, 1'b0, 1'b1);  // addi
    run(7'b0011011, 2, 0, 1'b1, 1'b0);  // addiw illegal
    run(7'b0011011, 0, 0, 1'b0, 1'b0);  // addiw
    run(7'b1100011, 0, 0, 1'b0, 1'b1);  // branch
    run(7'b1101111, 1, 0, 1'b0, 1'b1);  // jal
    run(7'b0110111, 0, 0, 1'b0, 1'b1);  // lui
    run(7'b0010111, 0, 0, 1'b0, 1'b0);  // auipc
    run(7'b0001111, 0, 0, 1'b0, 1'b1);  // fence
    run(7'b0000011, 0, 0, 1'b0, 1'b1);  // load, immediate done

    // Store interrupted by reset in its 2nd MEMWRITE cycle.
    build(7'b0100011, 0, 3, 1'b0, 1'b0);
    play(7'b0100011, 5);
    #3;
    chk_en = 1'b0;
    arstn  = 1'b0;
    #1;
    lit("reset_mid_store", dut_vec, 17'h00000);
    @(negedge clk);
    arstn = 1'b1;
    #1;
    lit("fetch_after_store_reset", dut_vec, 17'h10000);

    run(7'b0110011, 1, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
